// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: operation handshake out, result handshake back.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [3:0]       mode;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;

    modport master (
        output req_valid, rs1, rs2, mode, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, rs1, rs2, mode, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU between two requesters.
// Grant in p0, operation in flight through the ALU in p1, result buffered in p2.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_arbiter_if.slave     req0,
    alu_arbiter_if.slave     req1,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [3:0]       alu_mode,
    input  logic [WIDTH-1:0] alu_rd
);

    logic [1:0]       elig_p0;
    logic [1:0]       grant_p0;
    logic             last_grant;
    logic             inflight_vld_p1;
    logic             inflight_id_p1;
    logic             inflight_err_p1;
    logic [1:0]       resp_vld_p2;
    logic [1:0]       resp_err_p2;
    logic [1:0]       pop_p2;
    logic [WIDTH-1:0] resp_data_p2 [2];

    function automatic logic mode_illegal(input logic [3:0] mode);
        case (mode)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: mode_illegal = 1'b0;
            default:                                     mode_illegal = 1'b1;
        endcase
    endfunction

    // p0: eligibility, round-robin grant and operand steering
    always_comb begin
        elig_p0[0]  = req0.req_valid & ~resp_vld_p2[0] & ~(inflight_vld_p1 & ~inflight_id_p1);
        elig_p0[1]  = req1.req_valid & ~resp_vld_p2[1] & ~(inflight_vld_p1 &  inflight_id_p1);
        // On a tie the requester that did not win last time goes first
        grant_p0[0] = reset_n & elig_p0[0] & (~elig_p0[1] |  last_grant);
        grant_p0[1] = reset_n & elig_p0[1] & (~elig_p0[0] | ~last_grant);
    end

    always_comb begin
        alu_rs1  = '0;
        alu_rs2  = '0;
        alu_mode = 4'b1111;
        if (grant_p0[0]) begin
            alu_rs1  = req0.rs1;
            alu_rs2  = req0.rs2;
            alu_mode = req0.mode;
        end else if (grant_p0[1]) begin
            alu_rs1  = req1.rs1;
            alu_rs2  = req1.rs2;
            alu_mode = req1.mode;
        end
    end

    assign req0.req_ready = grant_p0[0];
    assign req1.req_ready = grant_p0[1];

    // p1: at most one operation in flight through the ALU register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_vld_p1 <= 1'b0;
            inflight_id_p1  <= 1'b0;
            inflight_err_p1 <= 1'b0;
            last_grant      <= 1'b1;
        end else begin
            inflight_vld_p1 <= |grant_p0;
            inflight_id_p1  <= grant_p0[1];
            inflight_err_p1 <= (|grant_p0) & mode_illegal(alu_mode);
            if (|grant_p0) begin
                last_grant <= grant_p0[1];
            end
        end
    end

    // p2: independent per-requester response buffers
    assign pop_p2[0] = resp_vld_p2[0] & req0.resp_ready;
    assign pop_p2[1] = resp_vld_p2[1] & req1.resp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_vld_p2 <= '0;
            resp_err_p2 <= '0;
            for (int i = 0; i < 2; i++) begin
                resp_data_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (inflight_vld_p1 && (inflight_id_p1 == 1'(i))) begin
                    resp_vld_p2[i]  <= 1'b1;
                    resp_data_p2[i] <= alu_rd;
                    resp_err_p2[i]  <= inflight_err_p1;
                end else if (pop_p2[i]) begin
                    resp_vld_p2[i] <= 1'b0;
                end
            end
        end
    end

    assign req0.resp_valid = resp_vld_p2[0];
    assign req0.resp_data  = resp_data_p2[0];
    assign req0.resp_err   = resp_err_p2[0];
    assign req1.resp_valid = resp_vld_p2[1];
    assign req1.resp_data  = resp_data_p2[1];
    assign req1.resp_err   = resp_err_p2[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus directed sequences, results checked via per-requester queues.
module tb_alu_arbiter;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        id;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  mode;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] alu_rs1, alu_rs2, alu_rd;
    logic [3:0]  alu_mode;

    int   ntests = 0;
    int   nfail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t cur0, cur1, e0, e1;
    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) rq0();
    alu_arbiter_if #(.WIDTH(WIDTH)) rq1();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (rq0),
        .req1     (rq1),
        .alu_rs1  (alu_rs1),
        .alu_rs2  (alu_rs2),
        .alu_mode (alu_mode),
        .alu_rd   (alu_rd)
    );

    // Stand-in for the shared registered ALU
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] m);
        case (m)
            4'b0000: alu_model = a + b;
            4'b1000: alu_model = a - b;
            4'b0001: alu_model = a << b[4:0];
            4'b0010: alu_model = {31'b0, $signed(a) < $signed(b)};
            4'b0011: alu_model = {31'b0, a < b};
            4'b0100: alu_model = a ^ b;
            4'b0101: alu_model = a >> b[4:0];
            4'b1101: alu_model = 32'($signed(a) >>> b[4:0]);
            4'b0110: alu_model = a | b;
            4'b0111: alu_model = a & b;
            default: alu_model = 32'd0;
        endcase
    endfunction

    always @(posedge clk) alu_rd <= alu_model(alu_rs1, alu_rs2, alu_mode);

    function automatic vec_t mk(input logic id, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] m, input logic [31:0] d, input logic er);
        vec_t v;
        v.id = id; v.rs1 = a; v.rs2 = b; v.mode = m; v.exp_data = d; v.exp_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant observation pushes the expectation that travels with the accepted stimulus
    always @(negedge clk) begin
        if (reset_n) begin
            if (rq0.req_ready || rq1.req_ready) begin
                check("one_ready", 32'(rq0.req_ready & rq1.req_ready), 32'd0);
                if (rq0.req_ready) begin
                    q0.push_back(cur0);
                    check("alu_rs1_g0", alu_rs1, rq0.rs1);
                    check("alu_rs2_g0", alu_rs2, rq0.rs2);
                    check("alu_mode_g0", 32'(alu_mode), 32'(rq0.mode));
                end
                if (rq1.req_ready) begin
                    q1.push_back(cur1);
                    check("alu_rs1_g1", alu_rs1, rq1.rs1);
                    check("alu_rs2_g1", alu_rs2, rq1.rs2);
                    check("alu_mode_g1", 32'(alu_mode), 32'(rq1.mode));
                end
            end else begin
                check("alu_idle_mode", 32'(alu_mode), 32'hf);
            end
            if (rq0.resp_valid && rq0.resp_ready) begin
                if (q0.size() == 0) check("resp0_unexpected", 32'd1, 32'd0);
                else begin
                    e0 = q0.pop_front();
                    check("resp0_data", rq0.resp_data, e0.data);
                    check("resp0_err", 32'(rq0.resp_err), 32'(e0.err));
                end
            end
            if (rq1.resp_valid && rq1.resp_ready) begin
                if (q1.size() == 0) check("resp1_unexpected", 32'd1, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    check("resp1_data", rq1.resp_data, e1.data);
                    check("resp1_err", 32'(rq1.resp_err), 32'(e1.err));
                end
            end
        end
    end

    always @(negedge reset_n) begin
        q0.delete();
        q1.delete();
    end

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if ((id == 0) ? rq0.req_ready : rq1.req_ready) ok = 1'b1;
        end
        if (!ok) check($sformatf("grant_timeout%0d", id), 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !rq0.resp_valid && !rq1.resp_valid)
                done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic present(input vec_t v);
        if (v.id == 1'b0) begin
            rq0.rs1 = v.rs1; rq0.rs2 = v.rs2; rq0.mode = v.mode;
            cur0 = '{v.exp_data, v.exp_err};
            rq0.req_valid = 1'b1;
        end else begin
            rq1.rs1 = v.rs1; rq1.rs2 = v.rs2; rq1.mode = v.mode;
            cur1 = '{v.exp_data, v.exp_err};
            rq1.req_valid = 1'b1;
        end
    endtask

    task automatic run_op(input vec_t v);
        bit ok;
        present(v);
        wait_grant(int'(v.id), ok);
        tick();
        if (v.id == 1'b0) rq0.req_valid = 1'b0;
        else              rq1.req_valid = 1'b0;
        drain();
    endtask

    initial begin
        bit ok;
        bit g1;
        int last;
        int ngr;
        int g;

        rq0.req_valid = 1'b0; rq0.rs1 = '0; rq0.rs2 = '0; rq0.mode = '0; rq0.resp_ready = 1'b0;
        rq1.req_valid = 1'b0; rq1.rs1 = '0; rq1.rs2 = '0; rq1.mode = '0; rq1.resp_ready = 1'b0;
        cur0 = '0; cur1 = '0;

        vecs[0]  = mk(1'b0, 32'd5,         32'd7,      4'b0000, 32'd12,        1'b0);
        vecs[1]  = mk(1'b0, 32'd10,        32'd3,      4'b1000, 32'd7,         1'b0);
        vecs[2]  = mk(1'b1, 32'h8000_0000, 32'd4,      4'b1101, 32'hF800_0000, 1'b0);
        vecs[3]  = mk(1'b1, 32'd1,         32'd2,      4'b0011, 32'd1,         1'b0);
        vecs[4]  = mk(1'b1, 32'd3,         32'd4,      4'b1010, 32'd0,         1'b1);
        vecs[5]  = mk(1'b1, 32'd1,         32'd1,      4'b0000, 32'd2,         1'b0);
        vecs[6]  = mk(1'b0, 32'd1,         32'd5,      4'b0001, 32'd32,        1'b0);
        vecs[7]  = mk(1'b0, 32'hFFFF_FFFF, 32'd1,      4'b0010, 32'd1,         1'b0);
        vecs[8]  = mk(1'b1, 32'h0000_FF00, 32'h0FF0,   4'b0100, 32'h0000_F0F0, 1'b0);
        vecs[9]  = mk(1'b0, 32'h8000_0000, 32'd4,      4'b0101, 32'h0800_0000, 1'b0);
        vecs[10] = mk(1'b1, 32'h0000_00F0, 32'h0F,     4'b0110, 32'h0000_00FF, 1'b0);
        vecs[11] = mk(1'b0, 32'h0000_F0F0, 32'hFF00,   4'b0111, 32'h0000_F000, 1'b0);
        vecs[12] = mk(1'b0, 32'd9,         32'd9,      4'b1111, 32'd0,         1'b1);

        // Reset with both requesters asking
        rq0.resp_ready = 1'b1; rq1.resp_ready = 1'b1;
        rq0.rs1 = 32'd2; rq0.rs2 = 32'd3; rq0.mode = 4'b0000; cur0 = '{32'd5, 1'b0};
        rq1.rs1 = 32'd9; rq1.rs2 = 32'd4; rq1.mode = 4'b1000; cur1 = '{32'd5, 1'b0};
        rq0.req_valid = 1'b1; rq1.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(rq0.req_ready), 32'd0);
        check("rst_ready1", 32'(rq1.req_ready), 32'd0);
        check("rst_resp0_valid", 32'(rq0.resp_valid), 32'd0);
        check("rst_resp1_valid", 32'(rq1.resp_valid), 32'd0);
        check("rst_resp0_data", rq0.resp_data, 32'd0);
        check("rst_resp1_err", 32'(rq1.resp_err), 32'd0);
        check("rst_alu_mode", 32'(alu_mode), 32'hf);
        check("rst_alu_rs1", alu_rs1, 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("tie_first_r0", 32'(rq0.req_ready), 32'd1);
        check("tie_first_r1", 32'(rq1.req_ready), 32'd0);
        tick();
        rq0.req_valid = 1'b0;
        @(negedge clk);
        check("second_r1", 32'(rq1.req_ready), 32'd1);
        tick();
        rq1.req_valid = 1'b0;
        drain();

        // Single op latency and hold under back-pressure
        rq0.resp_ready = 1'b0;
        present(mk(1'b0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0));
        @(negedge clk);
        check("lat_ready_T", 32'(rq0.req_ready), 32'd1);
        check("lat_mode_T", 32'(alu_mode), 32'h0);
        tick();
        rq0.req_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_T1", 32'(rq0.resp_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_T2", 32'(rq0.resp_valid), 32'd1);
        check("lat_data_T2", rq0.resp_data, 32'd12);
        check("lat_err_T2", 32'(rq0.resp_err), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("hold_valid", 32'(rq0.resp_valid), 32'd1);
            check("hold_data", rq0.resp_data, 32'd12);
        end
        tick();
        rq0.resp_ready = 1'b1;
        drain();

        // Round robin with both requesters continuously valid
        present(mk(1'b0, 32'd10, 32'd3, 4'b1000, 32'd7, 1'b0));
        present(mk(1'b1, 32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, 1'b0));
        last = -1;
        ngr = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = -1;
            if (rq0.req_ready) g = 0;
            if (rq1.req_ready) g = 1;
            if (g >= 0) begin
                if (last >= 0) check("rr_alternate", 32'(g), 32'(1 - last));
                last = g;
                ngr++;
            end
        end
        tick();
        rq0.req_valid = 1'b0;
        rq1.req_valid = 1'b0;
        check("rr_grants", 32'(ngr), 32'd8);
        drain();

        // Held response blocks only its own requester
        rq0.resp_ready = 1'b0;
        present(mk(1'b0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0));
        wait_grant(0, ok);
        tick();
        present(mk(1'b0, 32'h0000_FF00, 32'h0FF0, 4'b0100, 32'h0000_F0F0, 1'b0));
        present(mk(1'b1, 32'd1, 32'd2, 4'b0011, 32'd1, 1'b0));
        g1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready0", 32'(rq0.req_ready), 32'd0);
            if (rq1.req_ready) g1 = 1'b1;
            tick();
            if (g1) rq1.req_valid = 1'b0;
        end
        check("bp_r1_granted", 32'(g1), 32'd1);
        check("bp_r1_done", 32'(q1.size()), 32'd0);
        check("bp_r0_held", rq0.resp_data, 32'd12);
        rq0.resp_ready = 1'b1;
        wait_grant(0, ok);
        tick();
        rq0.req_valid = 1'b0;
        drain();

        // Table of single operations across both requesters
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i]);
        end

        // Reset pulse while an operation is in flight
        present(mk(1'b0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0));
        wait_grant(0, ok);
        tick();
        rq0.req_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_resp", 32'(rq0.resp_valid), 32'd0);
        end
        tick();
        run_op(mk(1'b0, 32'h0000_00F0, 32'h0F, 4'b0110, 32'h0000_00FF, 1'b0));

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
